// File: rtl/mandelbrot_stream.sv
// mandelbrot_stream: scans a WIDTH x HEIGHT grid of c values. For each pixel it
// iterates z <= z^2 + c on a mandelbrot_alu and streams the saturated, shifted
// iteration count through a small FIFO as a valid/ready pixel stream.
//
// Fixed-point format (c and z): two's complement, BITWIDTH bits, BITWIDTH-3
// fraction bits, so the range is [-4, 4).
//
// mandelbrot_alu ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle request; operands are sampled with it
//   cr, ci, zr, zi    c and current z
//   zr_next, zi_next  z^2 + c, truncated to BITWIDTH bits (held until next result)
//   size              |z|^2 > 4 for the input z
//   overflow          z^2 + c did not fit in BITWIDTH bits
//   finished          one-cycle pulse two cycles after start
//
// mandelbrot_stream ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, abort                frame control
//   busy, done                  frame status (registered)
//   max_ctr, ctr_shift          iteration limit and output count shift
//   step_r, step_i              signed per-pixel / per-line c increments
//   cr_offset, ci_offset        signed c at x=0 / y=0
//   pix_valid, pix_ready        output stream handshake
//   pix_ctr, pix_eol, pix_eof   head entry of the output FIFO

module mandelbrot_alu #(
    parameter int unsigned BITWIDTH = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BITWIDTH-1:0] cr,
    input  logic [BITWIDTH-1:0] ci,
    input  logic [BITWIDTH-1:0] zr,
    input  logic [BITWIDTH-1:0] zi,
    output logic [BITWIDTH-1:0] zr_next,
    output logic [BITWIDTH-1:0] zi_next,
    output logic                size,
    output logic                overflow,
    output logic                finished
);
    localparam int unsigned Frac = BITWIDTH - 3;
    localparam int unsigned PW   = 2 * BITWIDTH + 2;
    localparam logic signed [PW-1:0] Four = PW'(4) << Frac;

    function automatic logic signed [PW-1:0] sext(input logic [BITWIDTH-1:0] a);
        return {{(PW - BITWIDTH){a[BITWIDTH-1]}}, a};
    endfunction

    // A value fits in BITWIDTH bits when all bits from the sign bit up agree.
    function automatic logic fits(input logic signed [PW-1:0] a);
        return (&a[PW-1:BITWIDTH-1]) | ~(|a[PW-1:BITWIDTH-1]);
    endfunction

    logic signed [PW-1:0] zr_w, zi_w;
    logic signed [PW-1:0] rr, ii, ri;
    logic signed [PW-1:0] rr_q, ii_q, ri_q, cr_q, ci_q;
    logic                 v1_q;
    logic signed [PW-1:0] sum, re, im;

    assign zr_w = sext(zr);
    assign zi_w = sext(zi);
    assign rr   = (zr_w * zr_w) >>> Frac;
    assign ii   = (zi_w * zi_w) >>> Frac;
    assign ri   = (zr_w * zi_w) >>> Frac;

    assign sum = rr_q + ii_q;
    assign re  = rr_q - ii_q + cr_q;
    assign im  = (ri_q <<< 1) + ci_q;

    // Stage 1: products and c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            cr_q <= '0;
            ci_q <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= start;
            if (start) begin
                rr_q <= rr;
                ii_q <= ii;
                ri_q <= ri;
                cr_q <= sext(cr);
                ci_q <= sext(ci);
            end
        end
    end

    // Stage 2: sums, escape test and overflow test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zr_next  <= '0;
            zi_next  <= '0;
            size     <= 1'b0;
            overflow <= 1'b0;
            finished <= 1'b0;
        end else begin
            finished <= v1_q;
            if (v1_q) begin
                zr_next  <= re[BITWIDTH-1:0];
                zi_next  <= im[BITWIDTH-1:0];
                size     <= sum > Four;
                overflow <= ~(fits(re) & fits(im));
            end
        end
    end
endmodule

module mandelbrot_stream #(
    parameter int unsigned BITWIDTH   = 10,
    parameter int unsigned CTRWIDTH   = 7,
    parameter int unsigned OUTWIDTH   = 4,
    parameter int unsigned WIDTH      = 320,
    parameter int unsigned HEIGHT     = 240,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    input  logic [CTRWIDTH-1:0]         max_ctr,
    input  logic [$clog2(CTRWIDTH)-1:0] ctr_shift,
    input  logic [BITWIDTH-1:0]         step_r,
    input  logic [BITWIDTH-1:0]         step_i,
    input  logic [BITWIDTH-1:0]         cr_offset,
    input  logic [BITWIDTH-1:0]         ci_offset,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic [OUTWIDTH-1:0]         pix_ctr,
    output logic                        pix_eol,
    output logic                        pix_eof
);
    localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = OUTWIDTH + 2;
    localparam int unsigned VW = (CTRWIDTH > OUTWIDTH) ? CTRWIDTH : OUTWIDTH + 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StEval,
        StEmit,
        StAbort
    } state_e;

    state_e              state_q;
    logic [BITWIDTH-1:0] cr_q, ci_q, zr_q, zi_q;
    logic [CTRWIDTH-1:0] ctr_q;
    logic                ovf_q;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic                busy_q, done_q;
    logic                pending_q;

    logic [EW-1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q, rd_ptr_q;

    logic [BITWIDTH-1:0] alu_zr, alu_zi;
    logic                alu_size, alu_ovf, alu_finished;
    logic                alu_start;

    logic                abort_take, last_x, last_y, escape;
    logic                fifo_empty, fifo_full, push, pop;
    logic [EW-1:0]       head, entry;
    logic [VW-1:0]       shifted;
    logic                sat;
    logic [OUTWIDTH-1:0] count;

    mandelbrot_alu #(
        .BITWIDTH (BITWIDTH)
    ) u_alu (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (alu_start),
        .cr       (cr_q),
        .ci       (ci_q),
        .zr       (zr_q),
        .zi       (zi_q),
        .zr_next  (alu_zr),
        .zi_next  (alu_zi),
        .size     (alu_size),
        .overflow (alu_ovf),
        .finished (alu_finished)
    );

    assign alu_start  = (state_q == StIssue);
    assign abort_take = abort && (state_q != StIdle);
    assign last_x     = (x_q == XW'(WIDTH - 1));
    assign last_y     = (y_q == YW'(HEIGHT - 1));
    assign escape     = alu_size | ovf_q | (ctr_q == max_ctr);

    // Output count: shift, then saturate to all-ones if it does not fit.
    assign shifted = VW'(ctr_q) >> ctr_shift;
    assign sat     = |(shifted >> OUTWIDTH);
    assign count   = sat ? {OUTWIDTH{1'b1}} : shifted[OUTWIDTH-1:0];
    assign entry   = {count, last_x, last_x & last_y};

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Full is judged at the start of the cycle; a same-cycle pop does not free a slot.
    assign push       = (state_q == StEmit) && !fifo_full && !abort_take;
    assign pop        = !fifo_empty && pix_ready;
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];

    assign pix_valid = !fifo_empty;
    assign pix_ctr   = head[EW-1:2];
    assign pix_eol   = head[1];
    assign pix_eof   = head[0];
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fifo_mem <= '{default: '0};
        end else if (abort_take) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q[AW-1:0]] <= entry;
                wr_ptr_q                   <= wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cr_q      <= '0;
            ci_q      <= '0;
            zr_q      <= '0;
            zi_q      <= '0;
            ctr_q     <= '0;
            ovf_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Tracks an ALU request whose finished pulse has not yet arrived.
            if (alu_start) begin
                pending_q <= 1'b1;
            end else if (alu_finished) begin
                pending_q <= 1'b0;
            end

            // The eof entry can only be popped after the engine is back in IDLE.
            if (pop && head[0] && !abort_take) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end

            if (abort_take && (state_q != StAbort)) begin
                state_q <= StAbort;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && !busy_q) begin
                            cr_q    <= cr_offset;
                            ci_q    <= ci_offset;
                            zr_q    <= '0;
                            zi_q    <= '0;
                            ctr_q   <= '0;
                            ovf_q   <= 1'b0;
                            x_q     <= '0;
                            y_q     <= '0;
                            busy_q  <= 1'b1;
                            state_q <= StIssue;
                        end
                    end
                    StIssue: begin
                        state_q <= StWait;
                    end
                    StWait: begin
                        if (alu_finished) begin
                            state_q <= StEval;
                        end
                    end
                    StEval: begin
                        if (escape) begin
                            state_q <= StEmit;
                        end else begin
                            zr_q    <= alu_zr;
                            zi_q    <= alu_zi;
                            ctr_q   <= ctr_q + CTRWIDTH'(1);
                            ovf_q   <= alu_ovf;
                            state_q <= StIssue;
                        end
                    end
                    StEmit: begin
                        if (!fifo_full) begin
                            zr_q  <= '0;
                            zi_q  <= '0;
                            ctr_q <= '0;
                            ovf_q <= 1'b0;
                            if (!last_x) begin
                                cr_q    <= cr_q + step_r;
                                x_q     <= x_q + XW'(1);
                                state_q <= StIssue;
                            end else if (!last_y) begin
                                cr_q    <= cr_offset;
                                ci_q    <= ci_q + step_i;
                                x_q     <= '0;
                                y_q     <= y_q + YW'(1);
                                state_q <= StIssue;
                            end else begin
                                // busy stays high until the FIFO drains.
                                state_q <= StIdle;
                            end
                        end
                    end
                    StAbort: begin
                        if (!pending_q || alu_finished) begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mandelbrot_stream.sv
module tb_mandelbrot_stream;
    localparam int unsigned BW = 10;
    localparam int unsigned CW = 7;
    localparam int unsigned OW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pix_ready = 1'b0;
    logic          busy, done, pix_valid, pix_eol, pix_eof;
    logic [CW-1:0] max_ctr = '0;
    logic [2:0]    ctr_shift = '0;
    logic [BW-1:0] step_r = '0;
    logic [BW-1:0] step_i = '0;
    logic [BW-1:0] cr_offset = '0;
    logic [BW-1:0] ci_offset = '0;
    logic [OW-1:0] pix_ctr;

    always #5 clk = ~clk;

    mandelbrot_stream #(
        .BITWIDTH   (BW),
        .CTRWIDTH   (CW),
        .OUTWIDTH   (OW),
        .WIDTH      (4),
        .HEIGHT     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .max_ctr   (max_ctr),
        .ctr_shift (ctr_shift),
        .step_r    (step_r),
        .step_i    (step_i),
        .cr_offset (cr_offset),
        .ci_offset (ci_offset),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_ctr   (pix_ctr),
        .pix_eol   (pix_eol),
        .pix_eof   (pix_eof)
    );

    // Frame configuration and expected per-pixel counts (pixel i in nibble i).
    typedef struct {
        logic [BW-1:0] cro;
        logic [BW-1:0] cio;
        logic [BW-1:0] sr;
        logic [BW-1:0] si;
        logic [CW-1:0] maxc;
        logic [2:0]    sh;
        int            exp_starts;
        logic [31:0]   exp_ctr;
    } vec_t;

    vec_t tbl [7];

    // Monitor: records handshakes, ALU requests and done pulses at the falling edge.
    int         starts_total = 0;
    int         done_total = 0;
    int         done_busy_err = 0;
    logic       prev_busy = 1'b0;
    logic [5:0] pix_q [$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (dut.alu_start) starts_total++;
            if (pix_valid && pix_ready) pix_q.push_back({pix_ctr, pix_eol, pix_eof});
            if (done) begin
                done_total++;
                if (busy || !prev_busy) done_busy_err++;
            end
        end
        prev_busy = busy;
    end

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input vec_t v);
        cr_offset = v.cro;
        ci_offset = v.cio;
        step_r    = v.sr;
        step_i    = v.si;
        max_ctr   = v.maxc;
        ctr_shift = v.sh;
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            tick(1);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " done seen"}, 32'(got), 32'd1);
        tick(3);
    endtask

    task automatic check_frame(input string tag, input vec_t v, input int base_s,
                               input int base_d, input int base_p, input int base_e);
        logic [31:0] act, e;
        check({tag, " pixel count"}, pix_q.size() - base_p, 32'd8);
        for (int i = 0; i < 8; i++) begin
            e = {26'd0, 4'(v.exp_ctr >> (4 * i)), (i % 4) == 3, i == 7};
            act = 32'hFFFF_FFFF;
            if (base_p + i < pix_q.size()) act = 32'(pix_q[base_p + i]);
            check($sformatf("%s px%0d {ctr,eol,eof}", tag, i), act, e);
        end
        check({tag, " alu starts"}, starts_total - base_s, v.exp_starts);
        check({tag, " done pulses"}, done_total - base_d, 32'd1);
        check({tag, " busy low with done"}, done_busy_err - base_e, 32'd0);
        check({tag, " idle after frame"}, {30'd0, busy, pix_valid}, 32'd0);
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        int base_s, base_d, base_p, base_e;
        apply(v);
        pix_ready = 1'b1;
        base_s = starts_total;
        base_d = done_total;
        base_p = pix_q.size();
        base_e = done_busy_err;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check({tag, " issue after start"}, {30'd0, dut.alu_start, busy}, 32'd3);
        wait_done(tag);
        check_frame(tag, v, base_s, base_d, base_p, base_e);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_s, base_d, base_p, base_e, k;

        tbl[0] = '{cro: 10'd0, cio: 10'd0, sr: 10'd0, si: 10'd0, maxc: 7'd0, sh: 3'd0,
                   exp_starts: 8, exp_ctr: 32'h0000_0000};
        tbl[1] = '{cro: 10'd0, cio: 10'd0, sr: 10'd0, si: 10'd0, maxc: 7'd5, sh: 3'd0,
                   exp_starts: 48, exp_ctr: 32'h5555_5555};
        tbl[2] = '{cro: 10'd0, cio: 10'd0, sr: 10'd0, si: 10'd0, maxc: 7'd100, sh: 3'd2,
                   exp_starts: 808, exp_ctr: 32'hFFFF_FFFF};
        tbl[3] = '{cro: 10'd0, cio: 10'd0, sr: 10'd0, si: 10'd0, maxc: 7'd40, sh: 3'd2,
                   exp_starts: 328, exp_ctr: 32'hAAAA_AAAA};
        // c = 3.0: escapes at count 1.
        tbl[4] = '{cro: 10'd384, cio: 10'd0, sr: 10'd0, si: 10'd0, maxc: 7'd10, sh: 3'd0,
                   exp_starts: 16, exp_ctr: 32'h1111_1111};
        // cr = 0, 3.0, -2.0 (wrapped), 1.0 (wrapped; overflow escape).
        tbl[5] = '{cro: 10'd0, cio: 10'd0, sr: 10'd384, si: 10'd0, maxc: 7'd6, sh: 3'd0,
                   exp_starts: 40, exp_ctr: 32'h3616_3616};
        // Line 1 has ci = 3.0i.
        tbl[6] = '{cro: 10'd0, cio: 10'd0, sr: 10'd0, si: 10'd384, maxc: 7'd6, sh: 3'd0,
                   exp_starts: 36, exp_ctr: 32'h1111_6666};

        tick(3);
        check("reset outputs", {26'd0, busy, done, pix_valid, pix_ctr == 4'd0, pix_eol, pix_eof},
              32'h4);
        rst_n = 1'b1;
        tick(2);

        for (int t = 0; t < 7; t++) run_frame($sformatf("vec%0d", t), tbl[t]);

        // Backpressure: four entries fill the FIFO, the fifth pixel stalls in EMIT.
        apply(tbl[1]);
        pix_ready = 1'b0;
        base_s = starts_total;
        base_d = done_total;
        base_p = pix_q.size();
        base_e = done_busy_err;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(300);
        check("bp starts at stall", starts_total - base_s, 32'd30);
        check("bp busy", 32'(busy), 32'd1);
        check("bp head", {25'd0, pix_valid, pix_ctr, pix_eol, pix_eof}, {25'd0, 1'b1, 4'd5, 2'b00});
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(50);
        check("bp starts still stalled", starts_total - base_s, 32'd30);
        check("bp head stable", {25'd0, pix_valid, pix_ctr, pix_eol, pix_eof},
              {25'd0, 1'b1, 4'd5, 2'b00});
        pix_ready = 1'b1;
        wait_done("bp");
        check_frame("bp", tbl[1], base_s, base_d, base_p, base_e);
        tick(20);
        check("bp mid-frame start ignored", starts_total - base_s, 32'd48);

        // Abort on the first ALU request of the third pixel.
        apply(tbl[1]);
        pix_ready = 1'b0;
        base_s = starts_total;
        base_d = done_total;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 1;
        for (int c = 0; c < 2000 && k < 13; c++) begin
            tick(1);
            if (dut.alu_start) k++;
        end
        check("abort reached pixel 3", k, 32'd13);
        check("abort fifo holds 2 before", {31'd0, pix_valid}, 32'd1);
        tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort flush", {31'd0, pix_valid}, 32'd0);
        check("abort busy while alu in flight", {31'd0, busy}, 32'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("abort busy after alu finished", {31'd0, busy}, 32'd0);
        tick(20);
        check("abort starts", starts_total - base_s, 32'd13);
        check("abort no done", done_total - base_d, 32'd0);
        check("abort start ignored", {30'd0, busy, pix_valid}, 32'd0);
        run_frame("restart", tbl[4]);

        // Asynchronous reset mid-frame.
        apply(tbl[1]);
        pix_ready = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(60);
        check("pre-reset valid", {30'd0, busy, pix_valid}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs",
              {25'd0, busy, done, pix_valid, pix_ctr == 4'd0, pix_eol, pix_eof, dut.alu_start},
              32'h8);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        run_frame("post-reset", tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
